// File: rtl/usb_rx.sv
// USB 1.1 receive engine: input sync, DPLL bit recovery, NRZI decode,
// SYNC detect, bit unstuffing and LSB-first byte assembly.
module usb_rx #(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int IDLE_BITS      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       usb_speed,
    input  logic       usb_rx_dp,
    input  logic       usb_rx_dm,
    input  logic       usb_tx_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic       rx_bit_pulse,
    output logic [1:0] line_state
);

    localparam int JW = $clog2(IDLE_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERR} state_t;

    state_t        state;
    logic [1:0]    sync1;
    logic [1:0]    ls_q;
    logic [4:0]    phase;
    logic [4:0]    ph_last;
    logic [4:0]    ph_half;
    logic          prev_lvl;   // level of the previous non-SE0 sample
    logic          j_lvl;      // idle (J) level learned before the packet
    logic          idle_ok;    // at least one J sample seen since SE0/takeover
    logic [3:0]    zcnt;
    logic [2:0]    onecnt;
    logic [2:0]    bitcnt;
    logic [6:0]    shreg;
    logic [JW-1:0] jcnt;
    logic          se0_seen;

    logic se0, lvl, nrzi_bit, sample;

    assign ph_last      = usb_speed ? 5'd3 : 5'd31;
    assign ph_half      = usb_speed ? 5'd2 : 5'd16;
    assign rx_bit_pulse = (phase == ph_half);
    assign sample       = rx_bit_pulse;
    assign se0          = (line_state == 2'b00);
    assign lvl          = line_state[0];
    assign nrzi_bit     = (lvl == prev_lvl);

    // Two-flop synchronizer on the raw line; ls_q keeps the prior value for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 2'b00;
            line_state <= 2'b00;
            ls_q       <= 2'b00;
        end else begin
            sync1      <= {usb_rx_dp, usb_rx_dm};
            line_state <= sync1;
            ls_q       <= line_state;
        end
    end

    // DPLL: free-running bit phase, re-centred on every line transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase <= 5'd0;
        else if (line_state != ls_q)
            phase <= 5'd1;
        else if (phase >= ph_last)
            phase <= 5'd0;
        else
            phase <= phase + 5'd1;
    end

    // Receive FSM: SYNC hunt, unstuff/assemble, EOP qualification, error recovery
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            prev_lvl  <= 1'b1;
            j_lvl     <= 1'b1;
            idle_ok   <= 1'b0;
            zcnt      <= 4'd0;
            onecnt    <= 3'd0;
            bitcnt    <= 3'd0;
            shreg     <= 7'd0;
            jcnt      <= '0;
            se0_seen  <= 1'b0;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            rx_active <= 1'b0;
            rx_eop    <= 1'b0;
            rx_error  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;
            if (usb_tx_oe) begin
                // our own transmitter owns the bus; relearn J once it lets go
                state   <= S_IDLE;
                idle_ok <= 1'b0;
                if (rx_active) begin
                    rx_error  <= 1'b1;
                    rx_active <= 1'b0;
                end
            end else if (sample) begin
                if (!se0)
                    prev_lvl <= lvl;
                case (state)
                    S_IDLE: begin
                        if (se0) begin
                            idle_ok <= 1'b0;
                        end else begin
                            idle_ok <= 1'b1;
                            if (idle_ok && lvl != prev_lvl) begin
                                // the J->K edge is itself the first SYNC zero
                                state <= S_SYNC;
                                j_lvl <= prev_lvl;
                                zcnt  <= 4'd1;
                            end
                        end
                    end
                    S_SYNC: begin
                        if (se0) begin
                            state    <= S_ERR;
                            jcnt     <= '0;
                            se0_seen <= 1'b1;
                        end else if (!nrzi_bit) begin
                            if (zcnt != 4'hF)
                                zcnt <= zcnt + 4'd1;
                        end else if (int'(zcnt) >= SYNC_MIN_ZEROS) begin
                            state     <= S_DATA;
                            rx_active <= 1'b1;
                            bitcnt    <= 3'd0;
                            onecnt    <= 3'd1;  // SYNC's closing 1 starts the run
                        end else begin
                            state    <= S_ERR;
                            jcnt     <= '0;
                            se0_seen <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        if (se0) begin
                            state <= S_EOP;
                        end else if (onecnt == 3'd6) begin
                            if (nrzi_bit) begin
                                rx_error  <= 1'b1;
                                rx_active <= 1'b0;
                                state     <= S_ERR;
                                jcnt      <= '0;
                                se0_seen  <= 1'b0;
                            end else begin
                                onecnt <= 3'd0;
                            end
                        end else begin
                            shreg  <= {nrzi_bit, shreg[6:1]};
                            onecnt <= nrzi_bit ? onecnt + 3'd1 : 3'd0;
                            if (bitcnt == 3'd7) begin
                                rx_data  <= {nrzi_bit, shreg};
                                rx_valid <= 1'b1;
                                bitcnt   <= 3'd0;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end
                    end
                    S_EOP: begin
                        if (!se0) begin
                            rx_active <= 1'b0;
                            if (lvl == j_lvl) begin
                                state   <= S_IDLE;
                                idle_ok <= 1'b1;
                                // a partial byte at EOP is dropped and flagged
                                if (bitcnt == 3'd0)
                                    rx_eop <= 1'b1;
                                else
                                    rx_error <= 1'b1;
                            end else begin
                                rx_error <= 1'b1;
                                state    <= S_ERR;
                                jcnt     <= '0;
                                se0_seen <= 1'b0;
                            end
                        end
                    end
                    S_ERR: begin
                        if (se0) begin
                            se0_seen <= 1'b1;
                            jcnt     <= '0;
                        end else if (lvl == j_lvl) begin
                            if (se0_seen || jcnt == JW'(IDLE_BITS - 1)) begin
                                state   <= S_IDLE;
                                idle_ok <= 1'b1;
                            end
                            jcnt     <= jcnt + JW'(1);
                            se0_seen <= 1'b0;
                        end else begin
                            jcnt     <= '0;
                            se0_seen <= 1'b0;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
